refclk_pll_supervisor: RTL and testbench
========================================

REFCLK_PLL_SUPERVISOR -- requirements
Module: refclk_pll_supervisor

Interface
REQ-001 SHALL have parameter NUM_PLLS, default 2: number of supervised PLL channels, 1..8.
REQ-002 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse length in refclk cycles, >=2.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronised-locked cycles required before declaring lock.
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum cycles in WAIT_LOCK before a retry, > LOCK_STABLE_CYCLES.
REQ-005 SHALL have parameter MAX_RETRIES, default 3: timeout-driven retries before FAIL.
REQ-006 SHALL have parameter CNT_W, default 8: width of each loss-of-lock counter.
REQ-007 SHALL have port refclk, input, 1: sole clock; all logic rising-edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port locked_in, input, NUM_PLLS: raw PLL locked flags, asynchronous to refclk.
REQ-010 SHALL have port restart, input, NUM_PLLS: per-channel one-cycle restart request.
REQ-011 SHALL have port clear_counts, input, 1: zero all loss-of-lock counters.
REQ-012 SHALL have port pll_rst, output, NUM_PLLS: registered reset to each PLL.
REQ-013 SHALL have port lock_ok, output, NUM_PLLS: channel qualified locked.
REQ-014 SHALL have port all_locked, output, 1: AND of all lock_ok, registered.
REQ-015 SHALL have port fail, output, NUM_PLLS: channel exhausted retries.
REQ-016 SHALL have port lol_count, output, NUM_PLLS*CNT_W: per-channel loss-of-lock count; channel i in bits [i*CNT_W +: CNT_W].

Function
REQ-017 SHALL pass each locked_in bit through a two-flop synchroniser; "lk" below denotes the second-flop output.
REQ-018 SHALL run one independent FSM per channel with states RESET, WAIT_LOCK, LOCKED, FAIL.
REQ-019 SHALL, in RESET, hold pll_rst=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK.
REQ-020 SHALL, in WAIT_LOCK, hold pll_rst=0; increment a stable counter each cycle lk=1; clear it on any cycle lk=0.
REQ-021 SHALL enter LOCKED when the stable counter reaches LOCK_STABLE_CYCLES; lock_ok=1 on the first LOCKED cycle.
REQ-022 SHALL, if LOCK_TIMEOUT_CYCLES elapse in WAIT_LOCK without lock, increment the retry count and enter RESET if retries < MAX_RETRIES, else enter FAIL.
REQ-023 SHALL, in LOCKED, on any cycle lk=0: increment lol_count (saturating at 2^CNT_W-1), clear retries, enter RESET next cycle, drop lock_ok that same next cycle.
REQ-024 SHALL, in FAIL, hold pll_rst=1, fail=1, lock_ok=0 until restart or rst.
REQ-025 SHALL, on restart[i]=1 in any state, clear retries and the timeout/stable counters of channel i and enter RESET next cycle; restart overrides all same-cycle transitions.
REQ-026 SHALL give clear_counts priority over a same-cycle lol_count increment (result 0).
REQ-027 SHALL, with LOCK_TIMEOUT exactly coinciding with stable count reaching LOCK_STABLE_CYCLES, take LOCKED.
REQ-028 SHALL register all_locked from lock_ok (one cycle later than the last lock_ok rising).

Reset
REQ-029 SHALL, while rst=1: every FSM in RESET with counters and retries 0, pll_rst=all ones, lock_ok=0, all_locked=0, fail=0, lol_count=0, synchronisers 0.
REQ-030 SHALL, after rst deasserts, keep pll_rst=1 for RST_CYCLES further cycles; rst mid-operation aborts any state identically.

Verification (bench params: NUM_PLLS=2, RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, CNT_W=2)
REQ-031 SHALL cover: rst released, locked_in=2'b11 steady -> pll_rst low after 4 cycles; lock_ok=2'b11 after 2 sync + 8 stable cycles; all_locked one cycle later.
REQ-032 SHALL cover: locked_in[0] held 0 -> three RESET pulses of 4 cycles (initial + 2 retries) each separated by 32 WAIT_LOCK cycles, then fail[0]=1, pll_rst[0]=1; channel 1 unaffected.
REQ-033 SHALL cover: locked_in[1] glitches low 1 cycle at stable count 5 -> counter restarts; lock_ok[1] only after 8 further consecutive high cycles.
REQ-034 SHALL cover: four loss-of-lock events on channel 0 -> lol_count[1:0] reads 1,2,3,3 (saturates); clear_counts coinciding with 5th event -> 0.
REQ-035 SHALL cover: restart[0] while in FAIL -> fail[0]=0 next cycle, 4-cycle pll_rst pulse, retries reset (two more retries permitted).
REQ-036 SHALL cover: rst asserted while channel 1 LOCKED -> next cycle lock_ok=0, pll_rst=2'b11, lol_count=0.

Source files
------------

// File: rtl/refclk_pll_supervisor.sv
`timescale 1ns/1ps
// refclk_pll_supervisor
// Sequences and supervises NUM_PLLS independent PLL channels. Each channel
// pulses its PLL reset, waits for a qualified lock, and retries on a lock
// timeout. Once the retries run out it parks in FAIL until it is restarted.
// Loss-of-lock events are counted per channel in saturating counters.
//
// Ports
//   refclk        sole clock, rising edge
//   rst           synchronous active-high reset
//   locked_in     raw PLL lock flags, asynchronous to refclk
//   restart       per-channel one-cycle restart request
//   clear_counts  zero all loss-of-lock counters
//   pll_rst       registered reset to each PLL
//   lock_ok       channel qualified locked
//   all_locked    registered AND of lock_ok
//   fail          channel exhausted its retries
//   lol_count     loss-of-lock counts, channel i at [i*CNT_W +: CNT_W]
//
// Per-channel FSM
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RESET     | pll_rst high for RST_CYCLES cycles
//   WAIT_LOCK | pll_rst low, counting stable lock cycles against a timeout
//   LOCKED    | lock qualified; any lk drop counts a loss-of-lock
//   FAIL      | retries exhausted; pll_rst and fail held until restart

module refclk_pll_supervisor #(
   parameter int NUM_PLLS            = 2,
   parameter int RST_CYCLES          = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 8
) (
   input  logic                      refclk,
   input  logic                      rst,
   input  logic [NUM_PLLS-1:0]       locked_in,
   input  logic [NUM_PLLS-1:0]       restart,
   input  logic                      clear_counts,
   output logic [NUM_PLLS-1:0]       pll_rst,
   output logic [NUM_PLLS-1:0]       lock_ok,
   output logic                      all_locked,
   output logic [NUM_PLLS-1:0]       fail,
   output logic [NUM_PLLS*CNT_W-1:0] lol_count
);

   typedef enum logic [1:0] {
      ST_RESET     = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_LOCKED    = 2'd2,
      ST_FAIL      = 2'd3
   } state_t;

   // One down-counter per channel serves both the reset pulse and the lock timeout.
   localparam int TMR_MAX = (RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int RTY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [STB_W-1:0] STB_TC   = STB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
   localparam logic [CNT_W-1:0] LOL_SAT  = '1;

   logic [NUM_PLLS-1:0] sync_1;
   logic [NUM_PLLS-1:0] lk;

   always_ff @(posedge refclk) begin
      if (rst) begin
         sync_1 <= '0;
         lk     <= '0;
      end else begin
         sync_1 <= locked_in;
         lk     <= sync_1;
      end
   end

   for (genvar i = 0; i < NUM_PLLS; i++) begin : g_ch
      state_t           state, state_nxt;
      logic [TMR_W-1:0] tmr, tmr_nxt;
      logic [STB_W-1:0] stb, stb_nxt;
      logic [RTY_W-1:0] rty, rty_nxt;
      logic [CNT_W-1:0] lol, lol_nxt;
      logic             pll_rst_q, lock_ok_q, fail_q;

      always_comb begin
         state_nxt = state;
         tmr_nxt   = tmr;
         stb_nxt   = stb;
         rty_nxt   = rty;
         lol_nxt   = lol;
         if (restart[i]) begin
            state_nxt = ST_RESET;
            tmr_nxt   = RST_LOAD;
            stb_nxt   = '0;
            rty_nxt   = '0;
         end else begin
            case (state)
               ST_RESET: begin
                  if (tmr == '0) begin
                     state_nxt = ST_WAIT_LOCK;
                     tmr_nxt   = TMO_LOAD;
                     stb_nxt   = '0;
                  end else begin
                     tmr_nxt = tmr - TMR_W'(1);
                  end
               end
               ST_WAIT_LOCK: begin
                  // Lock is tested before the timeout so a coincident finish locks.
                  if (lk[i] && (stb == STB_TC)) begin
                     state_nxt = ST_LOCKED;
                     stb_nxt   = '0;
                  end else if (tmr == '0) begin
                     stb_nxt = '0;
                     if (rty < RTY_MAX) begin
                        rty_nxt   = rty + RTY_W'(1);
                        state_nxt = ST_RESET;
                        tmr_nxt   = RST_LOAD;
                     end else begin
                        state_nxt = ST_FAIL;
                     end
                  end else begin
                     tmr_nxt = tmr - TMR_W'(1);
                     stb_nxt = lk[i] ? (stb + STB_W'(1)) : '0;
                  end
               end
               ST_LOCKED: begin
                  if (!lk[i]) begin
                     state_nxt = ST_RESET;
                     tmr_nxt   = RST_LOAD;
                     rty_nxt   = '0;
                     if (lol != LOL_SAT) begin
                        lol_nxt = lol + CNT_W'(1);
                     end
                  end
               end
               ST_FAIL: begin
                  state_nxt = ST_FAIL;
               end
               default: begin
                  state_nxt = ST_RESET;
                  tmr_nxt   = RST_LOAD;
               end
            endcase
         end
         if (clear_counts) begin
            lol_nxt = '0;
         end
      end

      // Outputs are registered from the next state so they line up with the state register.
      always_ff @(posedge refclk) begin
         if (rst) begin
            state     <= ST_RESET;
            tmr       <= RST_LOAD;
            stb       <= '0;
            rty       <= '0;
            lol       <= '0;
            pll_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
            fail_q    <= 1'b0;
         end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            stb       <= stb_nxt;
            rty       <= rty_nxt;
            lol       <= lol_nxt;
            pll_rst_q <= (state_nxt == ST_RESET) || (state_nxt == ST_FAIL);
            lock_ok_q <= (state_nxt == ST_LOCKED);
            fail_q    <= (state_nxt == ST_FAIL);
         end
      end

      assign pll_rst[i]                  = pll_rst_q;
      assign lock_ok[i]                  = lock_ok_q;
      assign fail[i]                     = fail_q;
      assign lol_count[i*CNT_W +: CNT_W] = lol;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         all_locked <= 1'b0;
      end else begin
         all_locked <= &lock_ok;
      end
   end

endmodule

// File: tb/tb_refclk_pll_supervisor.sv
`timescale 1ns/1ps
// Directed bench for refclk_pll_supervisor with small parameters
// (2 channels, 4-cycle reset, 8-cycle stable, 32-cycle timeout, 2 retries, 2-bit counters).

module tb_refclk_pll_supervisor;

   logic       refclk;
   logic       rst;
   logic [1:0] locked_in;
   logic [1:0] restart;
   logic       clear_counts;
   logic [1:0] pll_rst;
   logic [1:0] lock_ok;
   logic       all_locked;
   logic [1:0] fail;
   logic [3:0] lol_count;

   int checks = 0;
   int errors = 0;

   refclk_pll_supervisor #(
      .NUM_PLLS            (2),
      .RST_CYCLES          (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32),
      .MAX_RETRIES         (2),
      .CNT_W               (2)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .locked_in    (locked_in),
      .restart      (restart),
      .clear_counts (clear_counts),
      .pll_rst      (pll_rst),
      .lock_ok      (lock_ok),
      .all_locked   (all_locked),
      .fail         (fail),
      .lol_count    (lol_count)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One-cycle low pulse on a channel; returns one cycle after the LOCKED FSM
   // has seen the synchronised drop.
   task automatic lol_event(input int ch);
      locked_in[ch] = 1'b0;
      step(1);
      locked_in[ch] = 1'b1;
      step(2);
   endtask

   initial begin
      rst          = 1'b1;
      locked_in    = 2'b11;
      restart      = 2'b00;
      clear_counts = 1'b0;
      step(3);
      chk("rst_pll_rst",    8'(pll_rst),    8'h3);
      chk("rst_lock_ok",    8'(lock_ok),    8'h0);
      chk("rst_all_locked", 8'(all_locked), 8'h0);
      chk("rst_fail",       8'(fail),       8'h0);
      chk("rst_lol",        8'(lol_count),  8'h0);

      // Power-up lock with both inputs high.
      rst = 1'b0;
      step(3);
      chk("up_pll_rst_hold", 8'(pll_rst), 8'h3);
      step(1);
      chk("up_pll_rst_low",  8'(pll_rst), 8'h0);
      step(7);
      chk("up_lock_early",   8'(lock_ok), 8'h0);
      step(1);
      chk("up_lock_ok",      8'(lock_ok), 8'h3);
      chk("up_all_early",    8'(all_locked), 8'h0);
      step(1);
      chk("up_all_locked",   8'(all_locked), 8'h1);

      // Restart channel 1, then glitch it at stable count 5.
      restart = 2'b10;
      step(1);
      restart = 2'b00;
      chk("gl_lock_drop",  8'(lock_ok), 8'h1);
      chk("gl_pll_rst",    8'(pll_rst), 8'h2);
      step(7);
      locked_in = 2'b01;
      step(1);
      locked_in = 2'b11;
      step(9);
      chk("gl_not_yet",    8'(lock_ok), 8'h1);
      step(1);
      chk("gl_relock",     8'(lock_ok), 8'h3);

      // Loss-of-lock counting on channel 0 with saturation.
      lol_event(0);
      chk("lol1_count",   8'(lol_count), 8'h1);
      chk("lol1_lock_ok", 8'(lock_ok),   8'h2);
      step(1);
      chk("lol1_all",     8'(all_locked), 8'h0);
      step(11);
      chk("lol1_relock",  8'(lock_ok),   8'h3);
      lol_event(0);
      chk("lol2_count",   8'(lol_count), 8'h2);
      step(12);
      chk("lol2_relock",  8'(lock_ok),   8'h3);
      lol_event(0);
      chk("lol3_count",   8'(lol_count), 8'h3);
      step(12);
      chk("lol3_relock",  8'(lock_ok),   8'h3);
      lol_event(0);
      chk("lol4_sat",     8'(lol_count), 8'h3);
      step(12);
      chk("lol4_relock",  8'(lock_ok),   8'h3);

      // Fifth event with clear_counts on the same edge as the increment.
      locked_in[0] = 1'b0;
      step(1);
      locked_in[0] = 1'b1;
      step(1);
      clear_counts = 1'b1;
      step(1);
      clear_counts = 1'b0;
      chk("lol5_clear",   8'(lol_count), 8'h0);
      chk("lol5_lock_ok", 8'(lock_ok),   8'h2);
      step(12);
      chk("lol5_relock",  8'(lock_ok),   8'h3);

      // Channel 1 loss-of-lock so the reset check has a nonzero count to clear.
      lol_event(1);
      chk("lolc1_count",  8'(lol_count), 8'h4);
      step(12);
      chk("lolc1_relock", 8'(lock_ok),   8'h3);

      // rst while locked; channel 0 input held low afterwards.
      rst       = 1'b1;
      locked_in = 2'b10;
      step(1);
      chk("mid_rst_lock_ok", 8'(lock_ok),    8'h0);
      chk("mid_rst_pll_rst", 8'(pll_rst),    8'h3);
      chk("mid_rst_lol",     8'(lol_count),  8'h0);
      chk("mid_rst_all",     8'(all_locked), 8'h0);
      rst = 1'b0;

      // Channel 0 retries twice, then fails; channel 1 locks normally.
      step(3);
      chk("rt_hold",      8'(pll_rst), 8'h3);
      step(1);
      chk("rt_wait1",     8'(pll_rst), 8'h0);
      step(8);
      chk("rt_ch1_lock",  8'(lock_ok), 8'h2);
      step(23);
      chk("rt_wait1_end", 8'(pll_rst), 8'h0);
      step(1);
      chk("rt_pulse2",    8'(pll_rst), 8'h1);
      step(3);
      chk("rt_pulse2_end",8'(pll_rst), 8'h1);
      step(1);
      chk("rt_wait2",     8'(pll_rst), 8'h0);
      step(31);
      chk("rt_wait2_end", 8'(pll_rst), 8'h0);
      step(1);
      chk("rt_pulse3",    8'(pll_rst), 8'h1);
      step(3);
      chk("rt_pulse3_end",8'(pll_rst), 8'h1);
      step(1);
      chk("rt_wait3",     8'(pll_rst), 8'h0);
      step(31);
      chk("rt_wait3_end", 8'(pll_rst), 8'h0);
      chk("rt_no_fail",   8'(fail),    8'h0);
      step(1);
      chk("rt_fail",      8'(fail),    8'h1);
      chk("rt_fail_rst",  8'(pll_rst), 8'h1);
      chk("rt_ch1_ok",    8'(lock_ok), 8'h2);
      chk("rt_all",       8'(all_locked), 8'h0);
      step(5);
      chk("rt_fail_hold", 8'(fail),    8'h1);
      chk("rt_fail_prst", 8'(pll_rst), 8'h1);

      // Restart out of FAIL; two fresh retries before failing again.
      restart = 2'b01;
      step(1);
      restart = 2'b00;
      chk("rs_fail_clr",  8'(fail),    8'h0);
      chk("rs_pll_rst",   8'(pll_rst), 8'h1);
      step(3);
      chk("rs_pulse_end", 8'(pll_rst), 8'h1);
      step(1);
      chk("rs_wait",      8'(pll_rst), 8'h0);
      step(32);
      chk("rs_retry1",    8'(pll_rst), 8'h1);
      chk("rs_retry1_nf", 8'(fail),    8'h0);
      step(36);
      chk("rs_retry2",    8'(pll_rst), 8'h1);
      chk("rs_retry2_nf", 8'(fail),    8'h0);
      step(35);
      chk("rs_pre_fail",  8'(fail),    8'h0);
      step(1);
      chk("rs_fail",      8'(fail),    8'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
